i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Byte-level I2C target (slave) controller, the far end of the i2c master link; used for loopback and regression against the master.
- Samples bus SCL/SDA with the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, then receives write bytes or returns read bytes via a one-cycle request handshake.
- Open-drain output: drives SDA low only; no clock stretching.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target answers.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_in/sda_in (min 2).

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- reset_n  input  1  asynchronous active-low reset.
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- rx_data  output  8  last received write byte, MSB first on wire.
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- tx_data  input  8  byte to send on reads; sampled the cycle tx_req is high.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- rw  output  1  R/W bit of the current transfer (1 = read).
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, state IDLE, bit counter 0. Takes effect immediately, including mid-byte or mid-ACK; SDA is released at once.
- Synchronized scl_s/sda_s plus one registered copy each give edge detection.
- scl_rise/scl_fall: SCL edges.
- START: sda_s falls while scl_s high.
- STOP: sda_s rises while scl_s high.
- START or STOP takes priority over any other event in the same cycle.
- Data sampled on scl_rise; sda_oe updated only on scl_fall, so it never changes while SCL is high.
- Shift register 8 bits, MSB first; 4-bit bit counter 0..8; byte complete when count reaches 8; counter clears on START and at each ACK slot.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits. On the 8th scl_rise, latch rw. On the following scl_fall: if addr[7:1]==TARGET_ADDR -> ADDR_ACK, busy=1, sda_oe=1; else -> WAIT_STOP, sda_oe stays 0.
  - ADDR_ACK: on scl_fall after the ACK clock, release. rw=0 -> WR_DATA. rw=1 -> RD_DATA, pulsing tx_req one cycle at ACK scl_rise and driving tx_data[7] on this scl_fall.
  - WR_DATA: shift 8 bits. On the 8th scl_rise, rx_data loads and rx_valid pulses the next cycle. On scl_fall -> WR_ACK, sda_oe=1.
  - WR_ACK: on scl_fall release -> WR_DATA.
  - RD_DATA: sda_oe = ~bit for bits 7..0, each set on scl_fall. After bit 0's scl_fall window, release on the next scl_fall -> RD_ACK.
  - RD_ACK: sample master ACK on scl_rise. SDA low -> tx_req pulse, load byte, -> RD_DATA. SDA high (NACK) -> WAIT_STOP, sda_oe=0.
  - WAIT_STOP: ignore the bus until START or STOP.
- START in any state: release SDA, clear counter, -> ADDR; busy holds if already addressed (repeated START).
- STOP in any state: release SDA, busy=0 -> IDLE.
- Latency: rx_valid is 1 clk after the 8th data scl_rise plus synchronizer delay (SYNC_STAGES+1 clk from pad).
- tx_data must be stable the cycle tx_req is high; it is captured into the shift register that cycle.
- Partial byte followed by STOP: no rx_valid, data discarded.

Optional Feature:
- Macro: I2C_TARGET_GENERAL_CALL_EN.
- Defined: address 7'h00 with rw=0 is also ACKed and its write bytes are delivered on rx_data/rx_valid. 7'h00 with rw=1 is NACKed -> WAIT_STOP.
- Undefined: 7'h00 is treated as a mismatch.

Test Plan:
- START, addr 0x84 (0x42 write), byte 0xA5, STOP -> ACK low at both 9th clocks; rx_data=0xA5 with one rx_valid pulse; busy 1 then 0 after STOP.
- START, addr 0x86 (0x43) -> sda_oe stays 0 throughout; no rx_valid, no tx_req; busy stays 0.
- START, 0x85, tx_data=0x3C, master ACK, tx_data=0x81, master NACK, STOP -> wire bytes 0x3C then 0x81; exactly 2 tx_req pulses; SDA released after NACK.
- Write 0x11, repeated START, read 0x85 -> rx_valid once with 0x11; rw changes 0->1; busy stays high across the repeated START.
- reset_n low at bit 4 of a write byte -> sda_oe=0 immediately; outputs at reset values; next full transaction works.
- With I2C_TARGET_GENERAL_CALL_EN, START 0x00, byte 0x06 -> ACKed, rx_data=0x06; without the macro -> NACK, no rx_valid.

Source files
------------

// File: rtl/i2c_target.sv
// Byte-level I2C target: synchronizes SCL/SDA, detects START/STOP, answers TARGET_ADDR.
// Optional macro I2C_TARGET_GENERAL_CALL_EN also accepts general-call writes (address 7'h00).
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_d1_q, scl_d1_d;
    logic                   sda_d1_q, sda_d1_d;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic addr_hit;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_d1_d   = scl_s;
        sda_d1_d   = sda_s;
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP require SCL high on both samples so they never coincide with an SCL edge.
    assign scl_rise  = scl_s & ~scl_d1_q;
    assign scl_fall  = ~scl_s & scl_d1_q;
    assign start_det = scl_s & scl_d1_q & sda_d1_q & ~sda_s;
    assign stop_det  = scl_s & scl_d1_q & ~sda_d1_q & sda_s;

`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign addr_hit = (shreg_q[7:1] == TARGET_ADDR) ||
                      ((shreg_q[7:1] == 7'h00) && !shreg_q[0]);
`else
    assign addr_hit = (shreg_q[7:1] == TARGET_ADDR);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;

        // The read byte is captured during the single cycle tx_req is asserted.
        if (tx_req_q) begin
            shreg_d = tx_data;
        end

        if (start_det) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_ADDR;
        end else if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rw_d = sda_s;
                        end
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        cnt_d = 4'd0;
                        if (addr_hit) begin
                            state_d  = S_ADDR_ACK;
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = S_RD_DATA;
                            sda_oe_d = ~shreg_q[7];
                        end else begin
                            state_d  = S_WR_DATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shreg_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        state_d  = S_WR_ACK;
                        sda_oe_d = 1'b1;
                        cnt_d    = 4'd0;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_WR_DATA;
                        sda_oe_d = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    // MSB of the shifter is always the bit currently on the wire.
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q < 4'd8) begin
                            sda_oe_d = ~shreg_q[7];
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_RD_ACK;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                            cnt_d    = 4'd0;
                            state_d  = S_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_d1_q   <= scl_d1_d;
            sda_d1_q   <= sda_d1_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master with an open-drain wire model and
// scoreboard queues for written bytes and read bytes.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl;
    logic       msda;
    logic       sda_w;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       rw;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    logic oe_seen = 1'b0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] rdq[$];

    assign sda_w = msda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl_in  (scl),
        .sda_in  (sda_w),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rw      (rw),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_x(input logic v, output logic s);
        msda = v;
        wq();
        scl = 1'b1;
        wq();
        s = sda_w;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic start_c();
        msda = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        msda = 1'b0;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic stop_c();
        msda = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        msda = 1'b1;
        wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            b[i] = s;
        end
        bit_x(mack, s);
    endtask

    task automatic push_tx(input logic [7:0] b);
        txq.push_back(b);
        rdq.push_back(b);
        if (txq.size() == 1) tx_data = b;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] got);
        chk({tag, "_pending"}, 32'(rdq.size() != 0), 1);
        if (rdq.size() != 0) chk(tag, 32'(got), 32'(rdq.pop_front()));
    endtask

    // Scoreboard consumers: written bytes and read-byte requests.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (rx_valid) begin
            rx_cnt++;
            chk("rx_pending", 32'(rxq.size() != 0), 1);
            if (rxq.size() != 0) chk("rx_data", 32'(rx_data), 32'(rxq.pop_front()));
        end
    end

    always begin
        @(negedge clk);
        if (tx_req) begin
            txreq_cnt++;
            chk("tx_pending", 32'(txq.size() != 0), 1);
            @(posedge clk);
            #1;
            if (txq.size() != 0) void'(txq.pop_front());
            tx_data = (txq.size() != 0) ? txq[0] : 8'hFF;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL timeout: simulation exceeded cycle budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] b;
        int         rx0;
        int         tr0;
        logic [7:0] pat[4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};

        reset_n = 1'b0;
        scl     = 1'b1;
        msda    = 1'b1;
        tx_data = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_rw", 32'(rw), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        wq();

        // Single write byte
        start_c();
        write_byte(8'h84, ack);
        chk("t1_addr_ack", 32'(ack), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rw", 32'(rw), 0);
        rxq.push_back(8'hA5);
        write_byte(8'hA5, ack);
        chk("t1_data_ack", 32'(ack), 0);
        stop_c();
        chk("t1_busy_stop", 32'(busy), 0);
        chk("t1_rx_data", 32'(rx_data), 'hA5);
        chk("t1_rx_cnt", rx_cnt, 1);

        // Multi-byte write with edge patterns
        start_c();
        write_byte(8'h84, ack);
        chk("t1b_addr_ack", 32'(ack), 0);
        foreach (pat[i]) begin
            rxq.push_back(pat[i]);
            write_byte(pat[i], ack);
            chk("t1b_data_ack", 32'(ack), 0);
        end
        stop_c();
        chk("t1b_rx_cnt", rx_cnt, 5);

        // Wrong address is ignored
        oe_seen = 1'b0;
        rx0 = rx_cnt;
        tr0 = txreq_cnt;
        start_c();
        write_byte(8'h86, ack);
        chk("t2_addr_nack", 32'(ack), 1);
        chk("t2_busy", 32'(busy), 0);
        write_byte(8'h00, ack);
        chk("t2_data_nack", 32'(ack), 1);
        stop_c();
        chk("t2_oe_seen", 32'(oe_seen), 0);
        chk("t2_rx_cnt", rx_cnt, rx0);
        chk("t2_txreq_cnt", txreq_cnt, tr0);

        // Two-byte read, ACK then NACK
        tr0 = txreq_cnt;
        push_tx(8'h3C);
        push_tx(8'h81);
        start_c();
        write_byte(8'h85, ack);
        chk("t3_addr_ack", 32'(ack), 0);
        chk("t3_rw", 32'(rw), 1);
        read_byte(1'b0, b);
        rd_expect("t3_rd0", b);
        read_byte(1'b1, b);
        rd_expect("t3_rd1", b);
        wq();
        chk("t3_released", 32'(sda_oe), 0);
        stop_c();
        chk("t3_txreq_cnt", txreq_cnt - tr0, 2);
        chk("t3_busy_stop", 32'(busy), 0);

        // Write, repeated START, read
        rx0 = rx_cnt;
        start_c();
        write_byte(8'h84, ack);
        chk("t4_addr_ack", 32'(ack), 0);
        rxq.push_back(8'h11);
        write_byte(8'h11, ack);
        chk("t4_data_ack", 32'(ack), 0);
        chk("t4_rw_wr", 32'(rw), 0);
        start_c();
        chk("t4_busy_rs", 32'(busy), 1);
        push_tx(8'h5A);
        write_byte(8'h85, ack);
        chk("t4_raddr_ack", 32'(ack), 0);
        chk("t4_rw_rd", 32'(rw), 1);
        chk("t4_busy_rd", 32'(busy), 1);
        read_byte(1'b1, b);
        rd_expect("t4_rd", b);
        stop_c();
        chk("t4_busy_stop", 32'(busy), 0);
        chk("t4_rx_cnt", rx_cnt - rx0, 1);
        chk("t4_rx_data", 32'(rx_data), 'h11);

        // Reset while the address ACK is being driven
        start_c();
        for (int i = 7; i >= 0; i--) bit_x(pat[0][i] | (8'h84 >> i) & 1'b1, s);
        msda = 1'b1;
        wq();
        chk("t5a_oe_ack", 32'(sda_oe), 1);
        reset_n = 1'b0;
        #1;
        chk("t5a_oe_rst", 32'(sda_oe), 0);
        chk("t5a_busy_rst", 32'(busy), 0);
        scl = 1'b1;
        wq();
        reset_n = 1'b1;
        wq();

        // Reset at bit 4 of a write byte, then a full transaction
        start_c();
        write_byte(8'h84, ack);
        chk("t5b_addr_ack", 32'(ack), 0);
        bit_x(1'b1, s);
        bit_x(1'b0, s);
        bit_x(1'b1, s);
        bit_x(1'b0, s);
        msda = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        reset_n = 1'b0;
        #1;
        chk("t5b_oe", 32'(sda_oe), 0);
        chk("t5b_rx_data", 32'(rx_data), 0);
        chk("t5b_rx_valid", 32'(rx_valid), 0);
        chk("t5b_tx_req", 32'(tx_req), 0);
        chk("t5b_rw", 32'(rw), 0);
        chk("t5b_busy", 32'(busy), 0);
        wq();
        reset_n = 1'b1;
        wq();
        start_c();
        write_byte(8'h84, ack);
        chk("t5c_addr_ack", 32'(ack), 0);
        rxq.push_back(8'hC3);
        write_byte(8'hC3, ack);
        chk("t5c_data_ack", 32'(ack), 0);
        stop_c();
        chk("t5c_rx_data", 32'(rx_data), 'hC3);

        // General call address
        rx0 = rx_cnt;
        start_c();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GENERAL_CALL_EN
        chk("t6_gc_ack", 32'(ack), 0);
        rxq.push_back(8'h06);
        write_byte(8'h06, ack);
        chk("t6_gc_data_ack", 32'(ack), 0);
        stop_c();
        chk("t6_rx_cnt", rx_cnt - rx0, 1);
        chk("t6_rx_data", 32'(rx_data), 'h06);
`else
        chk("t6_gc_nack", 32'(ack), 1);
        write_byte(8'h06, ack);
        chk("t6_gc_data_nack", 32'(ack), 1);
        stop_c();
        chk("t6_rx_cnt", rx_cnt, rx0);
`endif
        chk("t6_busy", 32'(busy), 0);

        // Partial byte then STOP is discarded
        rx0 = rx_cnt;
        start_c();
        write_byte(8'h84, ack);
        chk("t7_addr_ack", 32'(ack), 0);
        bit_x(1'b1, s);
        bit_x(1'b1, s);
        bit_x(1'b0, s);
        stop_c();
        chk("t7_rx_cnt", rx_cnt, rx0);
        chk("t7_busy", 32'(busy), 0);

        wq();
        chk("end_rxq", rxq.size(), 0);
        chk("end_rdq", rdq.size(), 0);
        chk("end_txq", txq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
